// File: rtl/rob_divider_seq.sv
// rtl/rob_divider_seq.sv - sequential signed 64/32 divider, restoring or rounded power-of-two (ROUND_DIVISOR_EN)
// Magnitudes use the multiplier's XOR (ones'-complement) sign convention.
module rob_divider_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] dvd_r;
    logic [31:0] dvs_r;
    logic [31:0] rem_acc;
    logic [30:0] d_low;
    logic [29:0] q_acc;
    logic [4:0]  count;

    logic [63:0] mag_d;
    logic [31:0] mag_v;
    logic        q_sign;
    logic        r_sign;
    logic [31:0] sat_q;
    logic        v_zero;

    assign mag_d  = dvd_r ^ {64{dvd_r[63]}};
    assign mag_v  = dvs_r ^ {32{dvs_r[31]}};
    assign q_sign = dvd_r[63] ^ dvs_r[31];
    assign r_sign = dvd_r[63];
    assign sat_q  = 32'h7FFF_FFFF ^ {32{q_sign}};
    assign v_zero = (mag_v == 32'd0);

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    logic [32:0] r_shift;
    logic        r_ge;
    logic [31:0] r_new;

    assign r_shift = {rem_acc, d_low[30]};
    assign r_ge    = (r_shift >= {1'b0, mag_v});
    assign r_new   = r_ge ? (r_shift[31:0] - mag_v) : r_shift[31:0];

`ifdef ROUND_DIVISOR_EN
    logic [4:0]  lead;
    logic        round_up;
    logic [5:0]  kp;
    logic [63:0] rq;
    logic [31:0] rmask;

    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag_v[i]) lead = 5'(i);
        end
        round_up = 1'b0;
        if (lead >= 5'd2) round_up = mag_v[lead - 5'd1];
        kp    = {1'b0, lead} + {5'd0, round_up};
        rq    = mag_d >> kp;
        rmask = kp[5] ? 32'hFFFF_FFFF : ((32'd1 << kp[4:0]) - 32'd1);
    end
`else
    logic prep_ovf;
    assign prep_ovf = (mag_d[63:31] >= {1'b0, mag_v});
`endif

    assign in_ready = (state == IDLE) && !rst;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = PREP;
            PREP: begin
`ifdef ROUND_DIVISOR_EN
                state_next = DONE;
`else
                if (v_zero || prep_ovf) state_next = DONE;
                else                    state_next = ITER;
`endif
            end
            ITER: if (count == 5'd0) state_next = DONE;
            DONE: if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results decided in PREP are published one cycle after entering DONE;
    // the iterative path raises out_valid together with its final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dvd_r       <= 64'd0;
            dvs_r       <= 32'd0;
            rem_acc     <= 32'd0;
            d_low       <= 31'd0;
            q_acc       <= 30'd0;
            count       <= 5'd0;
            out_valid   <= 1'b0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_r       <= dividend;
                        dvs_r       <= divisor;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                PREP: begin
                    if (v_zero) begin
                        div_by_zero <= 1'b1;
                        quotient    <= sat_q;
                        remainder   <= dvd_r[31:0];
`ifdef ROUND_DIVISOR_EN
                    end else if (|rq[63:31]) begin
                        overflow  <= 1'b1;
                        quotient  <= sat_q;
                        remainder <= 32'd0;
                    end else begin
                        quotient  <= {1'b0, rq[30:0]} ^ {32{q_sign}};
                        remainder <= (mag_d[31:0] & rmask) ^ {32{r_sign}};
                    end
`else
                    end else if (prep_ovf) begin
                        overflow  <= 1'b1;
                        quotient  <= sat_q;
                        remainder <= 32'd0;
                    end else begin
                        rem_acc <= mag_d[62:31];
                        d_low   <= mag_d[30:0];
                        q_acc   <= 30'd0;
                        count   <= 5'd30;
                    end
`endif
                end
                ITER: begin
                    rem_acc <= r_new;
                    d_low   <= {d_low[29:0], 1'b0};
                    q_acc   <= {q_acc[28:0], r_ge};
                    count   <= count - 5'd1;
                    if (count == 5'd0) begin
                        quotient  <= {1'b0, q_acc, r_ge} ^ {32{q_sign}};
                        remainder <= r_new ^ {32{r_sign}};
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_divider_seq.sv
// tb/tb_rob_divider_seq.sv - directed self-checking bench for rob_divider_seq (ROUND_DIVISOR_EN aware)
module tb_rob_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dz;
    logic        exp_ov;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rob_divider_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division on ones'-complement magnitudes.
    function automatic void model(input logic [63:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov, output int lat);
        logic [63:0] d;
        logic [31:0] v;
        logic        qs;
        logic        rs;
        logic [63:0] qq;
        logic [63:0] rr;
        int          k;
        qs = a[63] ^ b[31];
        rs = a[63];
        d  = a[63] ? ~a : a;
        v  = b[31] ? ~b : b;
        dz = 1'b0;
        ov = 1'b0;
        q  = 32'd0;
        r  = 32'd0;
        if (v == 32'd0) begin
            dz  = 1'b1;
            q   = qs ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r   = a[31:0];
            lat = 2;
        end else begin
`ifdef ROUND_DIVISOR_EN
            k = 31;
            while (!v[k]) k--;
            if (k >= 2 && v[k-1]) k++;
            qq  = d >> k;
            rr  = d % (64'd1 << k);
            lat = 2;
`else
            k   = 0;
            qq  = d / {32'd0, v};
            rr  = d % {32'd0, v};
            lat = 32 + k;
`endif
            if (qq >= 64'h8000_0000) begin
                ov  = 1'b1;
                q   = qs ? 32'h8000_0000 : 32'h7FFF_FFFF;
                r   = 32'd0;
                lat = 2;
            end else begin
                q = qq[31:0] ^ {32{qs}};
                r = rr[31:0] ^ {32{rs}};
            end
        end
    endfunction

    // Result must match the model on every cycle it is presented.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid) begin
            check("mon_quotient", {32'd0, quotient}, {32'd0, exp_q});
            check("mon_remainder", {32'd0, remainder}, {32'd0, exp_r});
            check("mon_div_by_zero", {63'd0, div_by_zero}, {63'd0, exp_dz});
            check("mon_overflow", {63'd0, overflow}, {63'd0, exp_ov});
        end
    end

    task automatic run_op(input logic [63:0] a, input logic [31:0] b, input int hold,
                          input logic use_lit, input logic [31:0] lq, input logic [31:0] lr,
                          input logic ldz, input logic lov, input int llat);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
        int          n0;
        int          waited;
        model(a, b, q, r, dz, ov, lat);
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_op", {63'd0, in_ready}, 64'd1);
        exp_q    = q;
        exp_r    = r;
        exp_dz   = dz;
        exp_ov   = ov;
        mon_en   = 1'b1;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        n0       = cyc;
        in_valid = 1'b0;
        check("in_ready_busy", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        while (!out_valid && (cyc - n0) < 100) @(negedge clk);
        check("out_valid_seen", {63'd0, out_valid}, 64'd1);
        check("latency", 64'(cyc - n0), 64'(lat));
        if (use_lit) begin
            check("lit_quotient", {32'd0, quotient}, {32'd0, lq});
            check("lit_remainder", {32'd0, remainder}, {32'd0, lr});
            check("lit_div_by_zero", {63'd0, div_by_zero}, {63'd0, ldz});
            check("lit_overflow", {63'd0, overflow}, {63'd0, lov});
            check("lit_latency", 64'(cyc - n0), 64'(llat));
        end
        repeat (hold) begin
            @(negedge clk);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        mon_en    = 1'b0;
        check("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 64'd0;
        divisor   = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_quotient", {32'd0, quotient}, 64'd0);
        check("rst_remainder", {32'd0, remainder}, 64'd0);
        check("rst_flags", {62'd0, div_by_zero, overflow}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);

`ifdef ROUND_DIVISOR_EN
        run_op(64'd100, 32'd7, 0, 1'b1, 32'd12, 32'd4, 1'b0, 1'b0, 2);
        run_op(64'hFFFF_FFFF_FFFF_FF9B, 32'd7, 0, 1'b1, 32'hFFFF_FFF3, 32'hFFFF_FFFB, 1'b0, 1'b0, 2);
        run_op(64'h0000_0000_7FFF_FFFF, 32'd1, 0, 1'b1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0, 2);
`else
        run_op(64'd100, 32'd7, 0, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0, 32);
        run_op(64'hFFFF_FFFF_FFFF_FF9B, 32'd7, 0, 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 1'b0, 1'b0, 32);
        run_op(64'h0000_0000_7FFF_FFFF, 32'd1, 0, 1'b1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0, 32);
`endif
        run_op(64'd100, 32'd0, 0, 1'b1, 32'h7FFF_FFFF, 32'd100, 1'b1, 1'b0, 2);
        run_op(64'd100, 32'hFFFF_FFFF, 0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        run_op(64'h0000_0001_0000_0000, 32'd1, 0, 1'b1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 2);
        run_op(64'h0000_0000_8000_0000, 32'd1, 0, 1'b1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 2);
        run_op(64'd1000, 32'hFFFF_FFF9, 10, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 32'h7FFF_FFFF, 0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        run_op(64'hFFFF_FFF0_0000_0000, 32'h0001_0000, 0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        run_op(64'd123456789, 32'd1000, 3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0);

        // Abort an operation in flight; previous result is nonzero so the clear is visible.
        in_valid = 1'b1;
        dividend = 64'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_quotient", {32'd0, quotient}, 64'd0);
        check("abort_remainder", {32'd0, remainder}, 64'd0);
        check("abort_flags", {62'd0, div_by_zero, overflow}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid_after", {63'd0, out_valid}, 64'd0);
`ifdef ROUND_DIVISOR_EN
        run_op(64'd100, 32'd7, 0, 1'b1, 32'd12, 32'd4, 1'b0, 1'b0, 2);
`else
        run_op(64'd100, 32'd7, 0, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0, 32);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
